// File: rtl/screen_fetcher.sv
// Video-side VRAM reader: fetches bitmap/attribute bytes per 8-pixel cell and
// shifts out one 256-pixel active line per accepted line_start pulse.
//
// Ports:
//   clk28, rst_n             28 MHz clock, synchronous active-low reset
//   line_start, row          line trigger, row latched on accepted pulse
//   vd                       VRAM read data
//   screen_fetch/addr        VRAM read request and address
//   screen_fetch_up/up_addr  palette read qualifier and index
//   pixel, attr, pixel_valid serialized pixel stream with its cell attribute
//   ink_rgb, paper_rgb       palette colours for the current cell
//   busy                     high while a line is being fetched or drained
//
// Optional feature: define ULAPLUS_FETCH_EN to add the two palette slots.
module screen_fetcher #(
   parameter int CELLS    = 32,
   parameter int SLOT_LEN = 4
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        line_start,
   input  logic [7:0]  row,
   input  logic [7:0]  vd,
   output logic        screen_fetch,
   output logic [14:0] screen_addr,
   output logic        screen_fetch_up,
   output logic [5:0]  screen_up_addr,
   output logic        pixel,
   output logic [7:0]  attr,
   output logic        pixel_valid,
   output logic [7:0]  ink_rgb,
   output logic [7:0]  paper_rgb,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_e;

`ifdef ULAPLUS_FETCH_EN
   localparam int NSLOT = 4;
`else
   localparam int NSLOT = 2;
`endif

   localparam logic [4:0] LAST_CYC  = 5'd31;
   localparam logic [4:0] LAST_COL  = 5'(CELLS - 1);
   localparam logic [4:0] BMP_END   = 5'(SLOT_LEN);
   localparam logic [4:0] ATR_END   = 5'(2 * SLOT_LEN);
   localparam logic [4:0] FETCH_END = 5'(NSLOT * SLOT_LEN);
   localparam logic [4:0] BMP_CAP   = 5'(SLOT_LEN - 1);
   localparam logic [4:0] ATR_CAP   = 5'(2 * SLOT_LEN - 1);

   state_e      state_q, state_d;
   logic [4:0]  col_q, col_d;
   logic [4:0]  cyc_q, cyc_d;
   logic [7:0]  row_q, row_d;

   logic        fetch_q, fetch_d;
   logic [14:0] addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        pv_q, pv_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  attr_q, attr_d;
   logic [7:0]  bmp_next_q, bmp_next_d;
   logic [7:0]  attr_next_q, attr_next_d;
   logic        load;
   logic        ls_ok;

   // Rows beyond the active area never start a line.
   assign ls_ok = line_start && (row < 8'd192);

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         cyc_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cyc_q   <= cyc_d;
         row_q   <= row_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cyc_d   = cyc_q;
      row_d   = row_q;
      if (ls_ok) begin
         state_d = FETCH;
         col_d   = '0;
         cyc_d   = '0;
         row_d   = row;
      end else begin
         unique case (state_q)
            FETCH: begin
               cyc_d = cyc_q + 5'd1;
               if (cyc_q == LAST_CYC) begin
                  if (col_q == LAST_COL) begin
                     state_d = DRAIN;
                     col_d   = '0;
                  end else begin
                     col_d = col_q + 5'd1;
                  end
               end
            end
            DRAIN: begin
               cyc_d = cyc_q + 5'd1;
               if (cyc_q == LAST_CYC) begin
                  state_d = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs are computed from the next state so they are
   // aligned with the slot they describe.
   always_comb begin
      fetch_d = (state_d == FETCH) && (cyc_d < FETCH_END);
      addr_d  = addr_q;
      if (state_d == FETCH && cyc_d < BMP_END) begin
         addr_d = {2'b10, row_d[7:6], row_d[2:0], row_d[5:3], col_d};
      end else if (state_d == FETCH && cyc_d < ATR_END) begin
         addr_d = {5'b10110, row_d[7:3], col_d};
      end
      busy_d = (state_d != IDLE);

      // Cell data is presented one cell after its fetch; an abort
      // suppresses the pending load.
      load = !ls_ok && (state_q == FETCH) && (cyc_q == LAST_CYC);

      pv_d = pv_q;
      if (ls_ok) begin
         pv_d = 1'b0;
      end else if (load) begin
         pv_d = 1'b1;
      end else if (state_q == DRAIN && cyc_q == LAST_CYC) begin
         pv_d = 1'b0;
      end

      shift_d = shift_q;
      if (load) begin
         shift_d = bmp_next_q;
      end else if (cyc_q[1:0] == 2'b11) begin
         shift_d = {shift_q[6:0], 1'b0};
      end

      attr_d = load ? attr_next_q : attr_q;

      bmp_next_d  = bmp_next_q;
      attr_next_d = attr_next_q;
      if (state_q == FETCH && cyc_q == BMP_CAP) begin
         bmp_next_d = vd;
      end
      if (state_q == FETCH && cyc_q == ATR_CAP) begin
         attr_next_d = vd;
      end
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         fetch_q     <= 1'b0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         pv_q        <= 1'b0;
         shift_q     <= '0;
         attr_q      <= '0;
         bmp_next_q  <= '0;
         attr_next_q <= '0;
      end else begin
         fetch_q     <= fetch_d;
         addr_q      <= addr_d;
         busy_q      <= busy_d;
         pv_q        <= pv_d;
         shift_q     <= shift_d;
         attr_q      <= attr_d;
         bmp_next_q  <= bmp_next_d;
         attr_next_q <= attr_next_d;
      end
   end

   assign screen_fetch = fetch_q;
   assign screen_addr  = addr_q;
   assign busy         = busy_q;
   assign pixel_valid  = pv_q;
   // Stale shift contents after an abort must not leak out.
   assign pixel        = shift_q[7] & pv_q;
   assign attr         = attr_q;

`ifdef ULAPLUS_FETCH_EN
   localparam logic [4:0] INK_END = 5'(3 * SLOT_LEN);
   localparam logic [4:0] UP_END  = 5'(4 * SLOT_LEN);
   localparam logic [4:0] INK_CAP = 5'(3 * SLOT_LEN - 1);
   localparam logic [4:0] PAP_CAP = 5'(4 * SLOT_LEN - 1);

   logic       up_q, up_d;
   logic [5:0] upa_q, upa_d;
   logic [7:0] ink_next_q, ink_next_d;
   logic [7:0] pap_next_q, pap_next_d;
   logic [7:0] ink_q, ink_d;
   logic [7:0] pap_q, pap_d;
   logic [7:0] attr_src;

   always_comb begin
      // Attribute byte lands on the same edge that enters the ink slot.
      attr_src = (state_q == FETCH && cyc_q == ATR_CAP) ? vd : attr_next_q;
      up_d = (state_d == FETCH) && (cyc_d >= ATR_END) && (cyc_d < UP_END);
      upa_d = upa_q;
      if (up_d && cyc_d < INK_END) begin
         upa_d = {attr_src[7:6], 1'b0, attr_src[2:0]};
      end else if (up_d) begin
         upa_d = {attr_src[7:6], 1'b1, attr_src[5:3]};
      end
      ink_next_d = ink_next_q;
      pap_next_d = pap_next_q;
      if (state_q == FETCH && cyc_q == INK_CAP) begin
         ink_next_d = vd;
      end
      if (state_q == FETCH && cyc_q == PAP_CAP) begin
         pap_next_d = vd;
      end
      ink_d = load ? ink_next_q : ink_q;
      pap_d = load ? pap_next_q : pap_q;
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         up_q       <= 1'b0;
         upa_q      <= '0;
         ink_next_q <= '0;
         pap_next_q <= '0;
         ink_q      <= '0;
         pap_q      <= '0;
      end else begin
         up_q       <= up_d;
         upa_q      <= upa_d;
         ink_next_q <= ink_next_d;
         pap_next_q <= pap_next_d;
         ink_q      <= ink_d;
         pap_q      <= pap_d;
      end
   end

   assign screen_fetch_up = up_q;
   assign screen_up_addr  = upa_q;
   assign ink_rgb         = ink_q;
   assign paper_rgb       = pap_q;
`else
   assign screen_fetch_up = 1'b0;
   assign screen_up_addr  = '0;
   assign ink_rgb         = '0;
   assign paper_rgb       = '0;
`endif

endmodule
